// File: rtl/alu_req_sequencer_if.sv
// Bundle of requester, response, ALU-side and status signals for alu_req_sequencer.
// slave = sequencer side, master = requesters plus the external add_sub unit.
interface alu_req_sequencer_if #(
  parameter int DW = 3,
  parameter int RW = 4
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic          req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          resp0_valid;
  logic          resp0_ready;
  logic          resp1_valid;
  logic          resp1_ready;
  logic [RW-1:0] resp_r;
  logic          resp_sf;
  logic          resp_zf;
  logic          alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [RW-1:0] alu_r;
  logic          alu_sf;
  logic          alu_zf;
  logic          busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp0_ready, resp1_ready,
    input  alu_r, alu_sf, alu_zf,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_r, resp_sf, resp_zf,
    output alu_op, alu_a, alu_b,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp0_ready, resp1_ready,
    output alu_r, alu_sf, alu_zf,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_r, resp_sf, resp_zf,
    input  alu_op, alu_a, alu_b,
    input  busy
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Two-requester sequencer in front of a shared combinational add_sub unit.
// Define ALU_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module alu_req_sequencer #(
  parameter int DW = 3,
  parameter int RW = 4
) (
  input logic               clk,
  input logic               rst,
  alu_req_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          grant;
  logic          grant_vld;
  logic          accept;
  logic          gid_q;
  logic          resp_take;

  logic          op_p0;
  logic [DW-1:0] a_p0;
  logic [DW-1:0] b_p0;
  logic [RW-1:0] r_p1;
  logic          sf_p1;
  logic          zf_p1;

`ifdef ALU_FIXED_PRIO_EN
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant     = ~bus.req0_valid;
  end
`else
  logic rr_last_q;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~rr_last_q;
    else                                  grant = bus.req1_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)                  rr_last_q <= 1'b1;
    else if (state_q == EXEC) rr_last_q <= gid_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign resp_take = gid_q ? bus.resp1_ready : bus.resp0_ready;

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          state_d        = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (resp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: operands captured at accept, held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0 <= 1'b0;
      a_p0  <= '0;
      b_p0  <= '0;
      gid_q <= 1'b0;
    end else if (accept) begin
      op_p0 <= grant ? bus.req1_op : bus.req0_op;
      a_p0  <= grant ? bus.req1_a  : bus.req0_a;
      b_p0  <= grant ? bus.req1_b  : bus.req0_b;
      gid_q <= grant;
    end
  end

  // p1: ALU result registered at the end of EXEC and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1  <= '0;
      sf_p1 <= 1'b0;
      zf_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      r_p1  <= bus.alu_r;
      sf_p1 <= bus.alu_sf;
      zf_p1 <= bus.alu_zf;
    end
  end

  assign bus.alu_op      = op_p0;
  assign bus.alu_a       = a_p0;
  assign bus.alu_b       = b_p0;
  assign bus.resp_r      = r_p1;
  assign bus.resp_sf     = sf_p1;
  assign bus.resp_zf     = zf_p1;
  assign bus.resp0_valid = (state_q == RESP) && !gid_q;
  assign bus.resp1_valid = (state_q == RESP) &&  gid_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
Two-requester sequencer that shares one combinational add_sub unit (3-bit sign-magnitude operands, 4-bit sign-magnitude result, SF/ZF flags).
- Arbitrates between requesters and captures the winning operation.
- Drives the shared ALU from registered operands and registers the ALU result and flags.
- Returns the response to the requester that issued the operation, using a valid/ready handshake on both sides.
- Sits between the operand-issuing control logic and the add_sub instance; the add_sub instance is external and wired to the alu_* ports.

Parameters:
DW, 3, operand width (bit DW-1 = sign, DW-2:0 = magnitude); must match add_sub.
RW, 4, result width (bit RW-1 = sign); must match add_sub.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  1  0 = A+B, 1 = A-B
req0_a  in  DW  operand A, sign-magnitude
req0_b  in  DW  operand B, sign-magnitude
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
resp0_valid  out  1  response pending for requester 0
resp0_ready  in  1  requester 0 takes response
resp1_valid  out  1  response pending for requester 1
resp1_ready  in  1  requester 1 takes response
resp_r  out  RW  registered ALU result, shared by both responses
resp_sf  out  1  registered sign flag
resp_zf  out  1  registered zero flag
alu_op  out  1  to add_sub OP
alu_a  out  DW  to add_sub A
alu_b  out  DW  to add_sub B
alu_r  in  RW  from add_sub R
alu_sf  in  1  from add_sub SF
alu_zf  in  1  from add_sub ZF
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0.
  - Operand registers 0, so alu_op/alu_a/alu_b = 0.
  - rr_last = 1, so requester 0 wins the first contention.
- Reset mid-operation drops the captured or pending transaction with no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant is combinational.
  - Only one reqN_valid high: that requester is granted.
  - Both high: the requester that is not rr_last is granted.
  - Only the granted reqN_ready = 1; the other ready = 0. No valid: both ready = 0.
  - On valid & ready: capture op/a/b into operand registers and the grant id into gid; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* are driven from the operand registers; they are always registered, never from req inputs.
  - At the clock edge: capture alu_r/alu_sf/alu_zf into resp_r/resp_sf/resp_zf; rr_last <= gid; go to RESP.
- RESP:
  - resp{gid}_valid = 1; the other resp valid = 0.
  - resp_r/sf/zf are held stable.
  - On resp{gid}_ready = 1: go to IDLE. resp_valid drops the next cycle.
  - resp_ready of the non-granted requester is ignored.
- Latency:
  - Accept edge at cycle N → resp_valid high in cycle N+2.
  - Minimum issue interval is 3 cycles; the block is not pipelined.
- Requester rules:
  - Must hold op/a/b stable while valid & !ready.
  - Must not deassert valid before ready.
  - Sampling happens only at the accept edge.
- Arithmetic: the block does no arithmetic. Results and flags pass through from add_sub unmodified, including -0 operands (sign=1, mag=0).
- Simultaneous events: a new request arriving during EXEC or RESP waits, with ready = 0. It is arbitrated in the next IDLE cycle using the updated rr_last.
- Fairness: with both valid continuously, grants alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention and rr_last is not used. Requester 1 is served only when req0_valid = 0 in the IDLE cycle.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then req0 op=0 a=3'b001 b=3'b010 → req0_ready in 1st cycle; resp0_valid 2 cycles after accept; resp_r=4'b0011, sf=0, zf=0.
- req1 op=1 a=3'b001 b=3'b010 → resp1_valid, resp_r=4'b1001, sf=1; resp0_valid stays 0.
- req0 op=1 a=3'b010 b=3'b010 → resp_r=4'b0000, zf=1, sf=0.
- Both valid continuously for 4 transactions → grant order 0,1,0,1. With ALU_FIXED_PRIO_EN → 0,0,0,0.
- Hold resp0_ready=0 for 5 cycles → resp0_valid and resp_r stable; busy=1; req1 ready=0 throughout; IDLE is re-entered only after resp0_ready=1.
- Assert rst during EXEC → next cycle busy=0, all resp valids 0, alu_a/alu_b=0; next request is served normally with requester 0 priority.
